// File: rtl/smol_decode_stage.sv
// Registered RV32I/RV64I decode stage: decodes the fetched word on accept and
// holds the bundle in an output register, optionally backed by a skid entry.
module smol_decode_stage #(
   parameter int XLEN        = 32,
   parameter int PC_W        = 32,
   parameter int ENABLE_SKID = 1
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     flush,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [31:0]              instr,
   input  logic [PC_W-1:0]          in_pc,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [PC_W-1:0]          out_pc,
   output logic [6:0]               opcode,
   output logic [4:0]               rd,
   output logic [4:0]               rs1,
   output logic [4:0]               rs2,
   output logic [2:0]               funct3,
   output logic [6:0]               funct7,
   output logic [$clog2(XLEN)-1:0]  shamt,
   output logic [XLEN-1:0]          imm,
   output logic [2:0]               imm_type,
   output logic                     illegal,
   output logic                     reg_write,
   output logic                     mem_read,
   output logic                     mem_write,
   output logic                     branch,
   output logic                     jump,
   output logic                     alu_src,
   output logic                     mem_to_reg,
   output logic [31:0]              dec_count
);

   localparam int SHW = $clog2(XLEN);

   typedef enum logic [2:0] {
      IMM_NONE = 3'd0,
      IMM_I    = 3'd1,
      IMM_S    = 3'd2,
      IMM_B    = 3'd3,
      IMM_U    = 3'd4,
      IMM_J    = 3'd5
   } imm_type_t;

   // ctl packs {reg_write, mem_read, mem_write, branch, jump, alu_src, mem_to_reg}
   typedef struct packed {
      logic [PC_W-1:0] pc;
      logic [6:0]      opcode;
      logic [4:0]      rd;
      logic [4:0]      rs1;
      logic [4:0]      rs2;
      logic [2:0]      funct3;
      logic [6:0]      funct7;
      logic [SHW-1:0]  shamt;
      logic [XLEN-1:0] imm;
      imm_type_t       imm_type;
      logic            illegal;
      logic [6:0]      ctl;
   } bundle_t;

   bundle_t     dec;
   bundle_t     out_q;
   bundle_t     skid_q;
   logic        out_valid_q;
   logic        skid_valid;
   logic [31:0] dec_count_q;
   imm_type_t   itype;
   logic [6:0]  ctl;
   logic        known;
   logic        bad;
   logic [31:0] imm32;
   logic        accept;
   logic        deliver;

   assign in_ready = (ENABLE_SKID != 0) ? !skid_valid : (!out_valid_q || out_ready);
   assign accept   = in_valid && in_ready;
   assign deliver  = out_valid_q && out_ready;

   // Word decode; illegal words keep their raw fields but lose imm and controls.
   always_comb begin
      itype = IMM_NONE;
      ctl   = 7'b0;
      known = 1'b1;
      case (instr[6:2])
         5'b01101, 5'b00101: begin itype = IMM_U; ctl = 7'b1000010; end
         5'b11011:           begin itype = IMM_J; ctl = 7'b1000100; end
         5'b11001:           begin itype = IMM_I; ctl = 7'b1000110; end
         5'b00000:           begin itype = IMM_I; ctl = 7'b1100011; end
         5'b00100:           begin itype = IMM_I; ctl = 7'b1000010; end
         5'b00011, 5'b11100: itype = IMM_I;
         5'b01000:           begin itype = IMM_S; ctl = 7'b0010010; end
         5'b11000:           begin itype = IMM_B; ctl = 7'b0001000; end
         5'b01100:           ctl = 7'b1000000;
         5'b00110: begin
            if (XLEN == 64) begin
               itype = IMM_I;
               ctl   = 7'b1000010;
            end else begin
               known = 1'b0;
            end
         end
         5'b01110: begin
            if (XLEN == 64) ctl = 7'b1000000;
            else            known = 1'b0;
         end
         default: known = 1'b0;
      endcase

      bad = !known || (instr[1:0] != 2'b11) || (instr == 32'h0000_0000) ||
            (instr == 32'hFFFF_FFFF);
      if (bad) begin
         itype = IMM_NONE;
         ctl   = 7'b0;
      end

      case (itype)
         IMM_I:   imm32 = {{20{instr[31]}}, instr[31:20]};
         IMM_S:   imm32 = {{20{instr[31]}}, instr[31:25], instr[11:7]};
         IMM_B:   imm32 = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
         IMM_U:   imm32 = {instr[31:12], 12'b0};
         IMM_J:   imm32 = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
         default: imm32 = 32'b0;
      endcase

      dec          = '0;
      dec.pc       = in_pc;
      dec.opcode   = instr[6:0];
      dec.rd       = instr[11:7];
      dec.rs1      = instr[19:15];
      dec.rs2      = instr[24:20];
      dec.funct3   = instr[14:12];
      dec.funct7   = instr[31:25];
      if (instr[6:0] == 7'b0010011 && instr[13:12] == 2'b01) begin
         dec.shamt = instr[20 +: SHW];
      end
      dec.imm      = XLEN'($signed(imm32));
      dec.imm_type = itype;
      dec.illegal  = bad;
      dec.ctl      = ctl;
   end

   // Output register plus skid entry; the skid only fills when the output is stalled.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_q       <= '0;
         skid_q      <= '0;
         out_valid_q <= 1'b0;
         skid_valid  <= 1'b0;
      end else if (flush) begin
         out_valid_q <= 1'b0;
         skid_valid  <= 1'b0;
      end else if (ENABLE_SKID != 0) begin
         if (!out_valid_q || out_ready) begin
            if (skid_valid) begin
               out_q       <= skid_q;
               out_valid_q <= 1'b1;
               skid_valid  <= 1'b0;
            end else if (accept) begin
               out_q       <= dec;
               out_valid_q <= 1'b1;
            end else begin
               out_valid_q <= 1'b0;
            end
         end else if (accept) begin
            skid_q     <= dec;
            skid_valid <= 1'b1;
         end
      end else begin
         if (accept) begin
            out_q       <= dec;
            out_valid_q <= 1'b1;
         end else if (out_ready) begin
            out_valid_q <= 1'b0;
         end
      end
   end

   // A deliver in a flush cycle still reaches downstream, so it is counted.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         dec_count_q <= 32'd0;
      end else if (deliver) begin
         dec_count_q <= dec_count_q + 32'd1;
      end
   end

   assign out_valid = out_valid_q;
   assign out_pc    = out_q.pc;
   assign opcode    = out_q.opcode;
   assign rd        = out_q.rd;
   assign rs1       = out_q.rs1;
   assign rs2       = out_q.rs2;
   assign funct3    = out_q.funct3;
   assign funct7    = out_q.funct7;
   assign shamt     = out_q.shamt;
   assign imm       = out_q.imm;
   assign imm_type  = out_q.imm_type;
   assign illegal   = out_q.illegal;
   assign {reg_write, mem_read, mem_write, branch, jump, alu_src, mem_to_reg} = out_q.ctl;
   assign dec_count = dec_count_q;

endmodule

// File: tb/tb_smol_decode_stage.sv
// Scoreboard bench: an RV32 skid instance and an RV64 no-skid instance share
// stimulus; a reference decoder fills per-instance queues checked by a monitor.
module tb_smol_decode_stage;

   typedef struct packed {
      logic [31:0] pc;
      logic [6:0]  opcode;
      logic [4:0]  rd;
      logic [4:0]  rs1;
      logic [4:0]  rs2;
      logic [2:0]  funct3;
      logic [6:0]  funct7;
      logic [5:0]  shamt;
      logic [63:0] imm;
      logic [2:0]  imm_type;
      logic        illegal;
      logic [6:0]  ctl;
   } bundle_t;

   logic clk = 1'b0;
   logic rst_n, flush, out_ready, in_valid_a, in_valid_b;
   logic [31:0] instr, in_pc;

   logic        a_in_ready, a_out_valid, a_illegal;
   logic [31:0] a_out_pc, a_imm, a_dec_count;
   logic [6:0]  a_opcode, a_funct7;
   logic [4:0]  a_rd, a_rs1, a_rs2, a_shamt;
   logic [2:0]  a_funct3, a_imm_type;
   logic [6:0]  a_ctl;

   logic        b_in_ready, b_out_valid, b_illegal;
   logic [31:0] b_out_pc, b_dec_count;
   logic [63:0] b_imm;
   logic [6:0]  b_opcode, b_funct7;
   logic [4:0]  b_rd, b_rs1, b_rs2;
   logic [5:0]  b_shamt;
   logic [2:0]  b_funct3, b_imm_type;
   logic [6:0]  b_ctl;

   bundle_t act_a, act_b;
   bundle_t q_a[$];
   bundle_t q_b[$];
   logic [31:0] cnt_a, cnt_b, pc_ctr;
   logic [31:0] dir_q[$];
   int sel;
   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   smol_decode_stage #(.XLEN(32), .PC_W(32), .ENABLE_SKID(1)) u_a (
      .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid_a), .in_ready(a_in_ready),
      .instr(instr), .in_pc(in_pc), .out_valid(a_out_valid), .out_ready(out_ready),
      .out_pc(a_out_pc), .opcode(a_opcode), .rd(a_rd), .rs1(a_rs1), .rs2(a_rs2),
      .funct3(a_funct3), .funct7(a_funct7), .shamt(a_shamt), .imm(a_imm),
      .imm_type(a_imm_type), .illegal(a_illegal), .reg_write(a_ctl[6]), .mem_read(a_ctl[5]),
      .mem_write(a_ctl[4]), .branch(a_ctl[3]), .jump(a_ctl[2]), .alu_src(a_ctl[1]),
      .mem_to_reg(a_ctl[0]), .dec_count(a_dec_count));

   smol_decode_stage #(.XLEN(64), .PC_W(32), .ENABLE_SKID(0)) u_b (
      .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid_b), .in_ready(b_in_ready),
      .instr(instr), .in_pc(in_pc), .out_valid(b_out_valid), .out_ready(out_ready),
      .out_pc(b_out_pc), .opcode(b_opcode), .rd(b_rd), .rs1(b_rs1), .rs2(b_rs2),
      .funct3(b_funct3), .funct7(b_funct7), .shamt(b_shamt), .imm(b_imm),
      .imm_type(b_imm_type), .illegal(b_illegal), .reg_write(b_ctl[6]), .mem_read(b_ctl[5]),
      .mem_write(b_ctl[4]), .branch(b_ctl[3]), .jump(b_ctl[2]), .alu_src(b_ctl[1]),
      .mem_to_reg(b_ctl[0]), .dec_count(b_dec_count));

   assign act_a = {a_out_pc, a_opcode, a_rd, a_rs1, a_rs2, a_funct3, a_funct7, 1'b0, a_shamt,
                   32'b0, a_imm, a_imm_type, a_illegal, a_ctl};
   assign act_b = {b_out_pc, b_opcode, b_rd, b_rs1, b_rs2, b_funct3, b_funct7, b_shamt,
                   b_imm, b_imm_type, b_illegal, b_ctl};

   task automatic checkOutput(input string name, input logic [159:0] act, input logic [159:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
      end
   endtask

   // Reference decoder: immediates are rebuilt by arithmetic shifts of the sign-extended word.
   function automatic bundle_t expectBundle(input logic [31:0] ins, input logic [31:0] pc, input int xlen);
      bundle_t     b;
      longint      sx;
      logic [63:0] v;
      int          kind;
      logic        rw, mr, mw, br, jp, as, mt, legal;
      b = '0;
      b.pc = pc; b.opcode = ins[6:0]; b.rd = ins[11:7]; b.rs1 = ins[19:15];
      b.rs2 = ins[24:20]; b.funct3 = ins[14:12]; b.funct7 = ins[31:25];
      if (ins[6:0] == 7'h13 && (ins[14:12] == 3'b001 || ins[14:12] == 3'b101))
         b.shamt = (xlen == 64) ? ins[25:20] : {1'b0, ins[24:20]};
      sx = longint'($signed(ins));
      {rw, mr, mw, br, jp, as, mt} = 7'b0;
      legal = 1'b1;
      kind = 0;
      case (ins[6:0])
         7'h37, 7'h17: begin kind = 4; rw = 1; as = 1; end
         7'h6F:        begin kind = 5; rw = 1; jp = 1; end
         7'h67:        begin kind = 1; rw = 1; jp = 1; as = 1; end
         7'h03:        begin kind = 1; rw = 1; mr = 1; as = 1; mt = 1; end
         7'h13:        begin kind = 1; rw = 1; as = 1; end
         7'h0F, 7'h73: kind = 1;
         7'h23:        begin kind = 2; mw = 1; as = 1; end
         7'h63:        begin kind = 3; br = 1; end
         7'h33:        rw = 1;
         7'h1B:        begin kind = 1; rw = 1; as = 1; legal = (xlen == 64); end
         7'h3B:        begin rw = 1; legal = (xlen == 64); end
         default:      legal = 1'b0;
      endcase
      if (ins == 32'h0 || ins == 32'hFFFF_FFFF) legal = 1'b0;
      if (!legal) begin
         b.illegal = 1'b1;
         return b;
      end
      case (kind)
         1:       v = 64'(sx >>> 20);
         2:       v = 64'(((sx >>> 25) <<< 5) | longint'(ins[11:7]));
         3:       v = 64'(((sx >>> 31) <<< 12) | (longint'(ins[7]) << 11) |
                          (longint'(ins[30:25]) << 5) | (longint'(ins[11:8]) << 1));
         4:       v = 64'(sx) & 64'hFFFF_FFFF_FFFF_F000;
         5:       v = 64'(((sx >>> 31) <<< 20) | (longint'(ins[19:12]) << 12) |
                          (longint'(ins[20]) << 11) | (longint'(ins[30:21]) << 1));
         default: v = 64'h0;
      endcase
      b.imm = (xlen == 32) ? {32'b0, v[31:0]} : v;
      b.imm_type = 3'(kind);
      b.ctl = {rw, mr, mw, br, jp, as, mt};
      return b;
   endfunction

   function automatic logic [31:0] randInstr();
      logic [31:0] w;
      int r;
      w = $urandom();
      r = int'($urandom_range(0, 19));
      case (r)
         0: w[6:0] = 7'h37;  1: w[6:0] = 7'h17;  2: w[6:0] = 7'h6F;  3: w[6:0] = 7'h67;
         4: w[6:0] = 7'h03;  5: w[6:0] = 7'h13;  6: w[6:0] = 7'h0F;  7: w[6:0] = 7'h73;
         8: w[6:0] = 7'h23;  9: w[6:0] = 7'h63;  10: w[6:0] = 7'h33; 11: w[6:0] = 7'h1B;
         12: w[6:0] = 7'h3B;
         13: begin w[6:0] = 7'h13; w[13:12] = 2'b01; end
         14: w = 32'h0;
         15: w = 32'hFFFF_FFFF;
         default: ;
      endcase
      return w;
   endfunction

   // One clock of stimulus towards the selected instance; the model is updated after the edge.
   task automatic applyStimulus(input logic v, input logic [31:0] ins, input logic [31:0] pc,
                                input logic ordy, input logic fl, output logic acc);
      logic rdy, exp_rdy;
      @(negedge clk);
      instr = ins; in_pc = pc; out_ready = ordy; flush = fl;
      in_valid_a = (sel == 0) && v;
      in_valid_b = (sel == 1) && v;
      #1;
      rdy     = (sel == 0) ? a_in_ready : b_in_ready;
      exp_rdy = (sel == 0) ? (q_a.size() < 2) : (q_b.size() == 0 || ordy);
      checkOutput(sel == 0 ? "in_ready_a" : "in_ready_b", 160'(rdy), 160'(exp_rdy));
      acc = v && rdy;
      @(posedge clk);
      #1;
      if (fl) begin
         q_a.delete();
         q_b.delete();
      end else if (acc) begin
         if (sel == 0) q_a.push_back(expectBundle(ins, pc, 32));
         else          q_b.push_back(expectBundle(ins, pc, 64));
      end
   endtask

   task automatic drainAll();
      int g = 0;
      logic acc;
      while ((q_a.size() != 0 || q_b.size() != 0) && g < 50) begin
         applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, acc);
         g++;
      end
      if (g >= 50) begin
         checks++; errors++;
         $display("[TB] FAIL drain_timeout: %0d/%0d entries still held", q_a.size(), q_b.size());
      end
   endtask

   task automatic runItems(input int n, input bit rnd, input int vld_pct, input int rdy_pct, input int fl_pct);
      int done = 0;
      int guard = 0;
      logic acc, v, r, f;
      logic [31:0] cur;
      cur = rnd ? randInstr() : dir_q.pop_front();
      while (done < n && guard < 40 * n + 100) begin
         v = $urandom_range(0, 99) < vld_pct;
         r = $urandom_range(0, 99) < rdy_pct;
         f = $urandom_range(0, 99) < fl_pct;
         applyStimulus(v, cur, pc_ctr, r, f, acc);
         guard++;
         if (acc) begin
            done++;
            pc_ctr += 32'd4;
            if (done < n) cur = rnd ? randInstr() : dir_q.pop_front();
         end
      end
      if (done < n) begin
         checks++; errors++;
         $display("[TB] FAIL stream_timeout: %0d of %0d accepted", done, n);
      end
      drainAll();
   endtask

   task automatic resetMid();
      @(negedge clk);
      in_valid_a = 1'b0; in_valid_b = 1'b0; flush = 1'b0; out_ready = 1'b0;
      #3 rst_n = 1'b0;
      #1;
      checkOutput("rst_out_valid_a", 160'(a_out_valid), 160'(0));
      checkOutput("rst_out_valid_b", 160'(b_out_valid), 160'(0));
      checkOutput("rst_dec_count_a", 160'(a_dec_count), 160'(0));
      checkOutput("rst_dec_count_b", 160'(b_dec_count), 160'(0));
      checkOutput("rst_in_ready_a", 160'(a_in_ready), 160'(1));
      q_a.delete(); q_b.delete();
      cnt_a = 32'd0; cnt_b = 32'd0;
      @(posedge clk);
      #1 rst_n = 1'b1;
   endtask

   // Monitor: compares whatever each instance presents against the head of its queue.
   initial begin
      forever begin
         @(negedge clk);
         #2;
         if (rst_n) begin
            checkOutput("out_valid_a", 160'(a_out_valid), 160'(q_a.size() != 0));
            if (a_out_valid && q_a.size() != 0) checkOutput("bundle_a", 160'(act_a), 160'(q_a[0]));
            checkOutput("dec_count_a", 160'(a_dec_count), 160'(cnt_a));
            if (q_a.size() != 0 && out_ready) begin
               void'(q_a.pop_front());
               cnt_a++;
            end
            checkOutput("out_valid_b", 160'(b_out_valid), 160'(q_b.size() != 0));
            if (b_out_valid && q_b.size() != 0) checkOutput("bundle_b", 160'(act_b), 160'(q_b[0]));
            checkOutput("dec_count_b", 160'(b_dec_count), 160'(cnt_b));
            if (q_b.size() != 0 && out_ready) begin
               void'(q_b.pop_front());
               cnt_b++;
            end
         end
      end
   end

   initial begin
      #2_000_000;
      errors++;
      $display("[TB] FAIL watchdog: simulation did not complete");
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      logic acc;
      logic saw_stall;
      int k;
      logic [31:0] skid_words[3];
      rst_n = 1'b0; flush = 1'b0; out_ready = 1'b0; in_valid_a = 1'b0; in_valid_b = 1'b0;
      instr = 32'h0; in_pc = 32'h0;
      cnt_a = 32'd0; cnt_b = 32'd0; pc_ctr = 32'h0; sel = 0;

      repeat (2) @(negedge clk);
      #1;
      checkOutput("reset_out_valid_a", 160'(a_out_valid), 160'(0));
      checkOutput("reset_in_ready_a", 160'(a_in_ready), 160'(1));
      checkOutput("reset_payload_a", 160'(act_a), 160'(0));
      checkOutput("reset_payload_b", 160'(act_b), 160'(0));
      checkOutput("reset_dec_count_a", 160'(a_dec_count), 160'(0));
      rst_n = 1'b1;

      $display("[TB] skid stream with two stalled cycles");
      skid_words[0] = 32'hFFF10093; skid_words[1] = 32'h123452B7; skid_words[2] = 32'hFE000EE3;
      k = 0; saw_stall = 1'b0;
      for (int c = 0; c < 20 && k < 3; c++) begin
         applyStimulus(1'b1, skid_words[k], 32'(k * 4), c >= 2, 1'b0, acc);
         if (acc) k++;
         else     saw_stall = 1'b1;
      end
      drainAll();
      checkOutput("skid_backpressure", 160'(saw_stall), 160'(1));
      checkOutput("skid_dec_count", 160'(a_dec_count), 160'(3));

      $display("[TB] directed words on RV32 skid instance");
      pc_ctr = 32'h100;
      dir_q = '{32'hFFF10093, 32'h123452B7, 32'hFE000EE3, 32'h00000000, 32'hFFFFFFFF,
                32'h0000000B, 32'h4030D093, 32'h4030D09B, 32'hFE112E23, 32'hFF1FF0EF,
                32'h000080E7, 32'hFFC12083, 32'h00001517, 32'h002081B3, 32'h0FF0000F,
                32'h00000073};
      runItems(16, 1'b0, 100, 100, 0);

      $display("[TB] directed words on RV64 instance");
      sel = 1;
      dir_q = '{32'h4030D093, 32'h0010809B, 32'h0020803B, 32'h0000000B, 32'h8000056F};
      runItems(5, 1'b0, 100, 60, 0);

      $display("[TB] randomized streams");
      runItems(250, 1'b1, 75, 65, 3);
      sel = 0;
      runItems(250, 1'b1, 75, 65, 3);

      $display("[TB] flush with both registers full");
      applyStimulus(1'b1, 32'h00100093, pc_ctr, 1'b0, 1'b0, acc);
      applyStimulus(1'b1, 32'h00200113, pc_ctr + 4, 1'b0, 1'b0, acc);
      applyStimulus(1'b1, 32'h00300193, pc_ctr + 8, 1'b0, 1'b1, acc);
      checkOutput("flush_out_valid", 160'(a_out_valid), 160'(0));
      checkOutput("flush_in_ready", 160'(a_in_ready), 160'(1));
      applyStimulus(1'b1, 32'h00400213, pc_ctr + 12, 1'b0, 1'b0, acc);
      applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 1'b1, acc);
      repeat (3) applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, acc);

      $display("[TB] reset mid-stream");
      applyStimulus(1'b1, 32'h00500293, 32'h200, 1'b0, 1'b0, acc);
      sel = 1;
      applyStimulus(1'b1, 32'h00600313, 32'h204, 1'b0, 1'b0, acc);
      resetMid();
      repeat (3) applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, acc);
      runItems(20, 1'b1, 80, 70, 0);
      sel = 0;
      runItems(20, 1'b1, 80, 70, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/smol_decode_stage.md
Name: smol_decode_stage

Overview:
Registered, parametrised RV32I/RV64I decode stage for SmolCore. It sits between fetch and register-read, and is the pipelined successor of the combinational decoder. It takes a fetched instruction and PC over a valid/ready handshake and extracts all fields. It generates the sign-extended immediate for every format, flags illegal encodings, produces main control signals, and holds results in an optional two-entry skid buffer.

Parameters:
XLEN, 32, datapath width; only 32 or 64 are legal; sets immediate width and shamt width (5 or 6 bits).
PC_W, 32, PC width carried alongside the instruction.
ENABLE_SKID, 1, 1 = two-entry skid buffer with registered in_ready; 0 = single output register with combinational in_ready.

Ports:
clk  in  1  stage clock, rising edge.
rst_n  in  1  asynchronous active-low reset.
flush  in  1  synchronous flush; discards held and incoming instructions.
in_valid  in  1  fetch presents instr/in_pc.
in_ready  out  1  stage can accept this cycle.
instr  in  32  instruction word.
in_pc  in  PC_W  instruction PC.
out_valid  out  1  decoded bundle valid.
out_ready  in  1  downstream accepts bundle.
out_pc  out  PC_W  PC of the decoded instruction.
opcode  out  7  instr[6:0].
rd, rs1, rs2  out  5 each  instr[11:7], [19:15], [24:20].
funct3  out  3  instr[14:12].
funct7  out  7  instr[31:25].
shamt  out  $clog2(XLEN)  instr[20 +: $clog2(XLEN)] for shift OP-IMM (funct3 001/101); otherwise 0.
imm  out  XLEN  sign-extended immediate.
imm_type  out  3  0 none, 1 I, 2 S, 3 B, 4 U, 5 J.
illegal  out  1  unsupported or malformed encoding.
reg_write, mem_read, mem_write, branch, jump, alu_src, mem_to_reg  out  1 each  main control.
dec_count  out  32  count of bundles handed downstream.

Behaviour:
- Reset (rst_n low, asynchronous): out_valid=0, skid empty, in_ready=1, every payload output=0, dec_count=0.
- Accept occurs when in_valid && in_ready. Deliver occurs when out_valid && out_ready. Latency from accept to out_valid is 1 cycle. Throughput is 1 per cycle while out_ready=1.
- ENABLE_SKID=1: in_ready = !skid_valid (registered).
  - Accept while the output register is full and no deliver happens: the bundle goes to skid.
  - Deliver with skid full: skid moves to the output register.
  - Strict FIFO order; no drop and no duplicate.
- ENABLE_SKID=0: in_ready = !out_valid || out_ready.
- Out-bundle stability: while out_valid && !out_ready, every out payload is held stable.
- Decode is done combinationally on instr and registered at accept. Opcode classes on instr[6:2]:
  - LUI 01101, AUIPC 00101: U type.
  - JAL 11011: J type.
  - JALR 11001, LOAD 00000, OP-IMM 00100, MISC-MEM 00011, SYSTEM 11100: I type.
  - STORE 01000: S type.
  - BRANCH 11000: B type.
  - OP 01100: R type, imm_type 0.
  - OP-IMM-32 00110 and OP-32 01110: valid only when XLEN=64.
- Immediates, all sign-extended from instr[31] to XLEN:
  - I: instr[31:20].
  - S: {instr[31:25], instr[11:7]}.
  - B: {instr[31], instr[7], instr[30:25], instr[11:8], 0}.
  - U: {instr[31:12], 12'b0}.
  - J: {instr[31], instr[19:12], instr[20], instr[30:21], 0}.
- illegal=1 when any of the following holds; the bundle is still delivered, with imm=0, imm_type=0 and all controls 0:
  - instr[1:0] != 11;
  - the opcode is unlisted, or is an RV64-only opcode with XLEN=32;
  - instr == 0x00000000 or instr == 0xFFFFFFFF.
- Controls:
  - R / OP-IMM: reg_write=1; alu_src=1 for OP-IMM only.
  - LOAD: reg_write, mem_read, alu_src, mem_to_reg.
  - STORE: mem_write, alu_src.
  - BRANCH: branch.
  - JAL / JALR: jump, reg_write; alu_src=1 for JALR.
  - LUI / AUIPC: reg_write, alu_src.
  - MISC-MEM / SYSTEM: all 0.
- flush: on the next edge out_valid=0 and skid is emptied; in_ready=1 in the following cycle. An accept coinciding with flush is discarded. A deliver coinciding with flush still counts. dec_count is not cleared.
- dec_count increments by 1 per deliver and wraps 0xFFFFFFFF to 0.
- Reset asserted mid-stream: all state clears immediately; nothing is delivered after reset release without a new accept.

Test Plan:
- XLEN=32, accept 0xFFF10093 (addi x1,x2,-1) -> next cycle out_valid=1, rd=1, rs1=2, imm=0xFFFFFFFF, imm_type=1, reg_write=1, alu_src=1, illegal=0.
- Accept 0x123452B7 (lui x5,0x12345) -> imm=0x12345000, imm_type=4, rd=5. Accept 0xFE000EE3 (beq x0,x0,-4) -> imm=0xFFFFFFFC, imm_type=3, branch=1, reg_write=0.
- Stream PCs 0x0, 0x4, 0x8 back-to-back with out_ready=0 for 2 cycles (ENABLE_SKID=1) -> in_ready=0 after 2 accepts, 0x8 held at input; out_pc delivered 0x0, 0x4, 0x8 in order; dec_count=3.
- Accept 0x00000000, 0xFFFFFFFF, 0x0000000B -> each delivered with illegal=1, all controls 0, imm=0.
- XLEN=64, 0x4030D093 (srai x1,x1,3) -> shamt=3, funct7=0x20. Same word with XLEN=32 on opcode 0011011 -> illegal=1.
- Both registers full, assert flush with in_valid=1 -> next cycle out_valid=0, in_ready=1, flushed input never appears. Pulse rst_n low mid-stream -> out_valid=0 and dec_count=0 asynchronously.
